// File: rtl/clint_responder.sv
// Core-local interruptor: msip, mtimecmp and mtime registers behind a single-outstanding valid/ready port.
// Optional macro CLINT_RTC_TICK_EN adds i_rtc_tick; mtime then advances only on ticks instead of every cycle.
module clint_responder #(
    parameter int cpu_max = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef CLINT_RTC_TICK_EN
    input  logic               i_rtc_tick,
`endif
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [47:0]        i_req_addr,
    input  logic               i_req_write,
    input  logic [63:0]        i_req_wdata,
    input  logic [7:0]         i_req_wstrb,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [63:0]        o_resp_rdata,
    output logic               o_resp_err,
    output logic [cpu_max-1:0] o_msip,
    output logic [cpu_max-1:0] o_mtip,
    output logic [63:0]        o_mtime
);

    localparam logic [47:0] clint_bar  = 48'h0000_0200_0000;
    localparam logic [47:0] clint_mask = 48'h0000_0000_ffff;
    localparam logic [12:0] mtime_word = 13'h17ff;          // byte offset 0xBFF8 as a 64-bit word index
    localparam logic [10:0] hart_count = 11'(cpu_max);
    localparam logic [10:0] msip_words = 11'((cpu_max + 1) / 2);

    typedef enum logic {
        st_idle,
        st_resp
    } state_t;

    typedef enum logic [1:0] {
        tgt_none,
        tgt_msip,
        tgt_mtimecmp,
        tgt_mtime
    } target_t;

    state_t             state;
    state_t             state_next;
    target_t            target;
    logic               region_hit;
    logic [10:0]        word_idx;
    logic               accept;
    logic               wr_en;
    logic               tick;
    logic [63:0]        wr_mask;
    logic [63:0]        rd_data;
    logic [63:0]        mtime;
    logic [63:0]        mtime_next;
    logic [63:0]        mtimecmp [cpu_max];
    logic [cpu_max-1:0] msip;

`ifdef CLINT_RTC_TICK_EN
    assign tick = i_rtc_tick;
`else
    assign tick = 1'b1;
`endif

    // ---------------- request/response FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= st_idle;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            st_idle: if (i_req_valid)  state_next = st_resp;
            st_resp: if (i_resp_ready) state_next = st_idle;
            default: state_next = st_idle;
        endcase
    end

    always_comb begin
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        case (state)
            st_idle: o_req_ready  = 1'b1;
            st_resp: o_resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = i_req_valid && o_req_ready;
    assign wr_en  = accept && i_req_write;

    // ---------------- address decode ----------------
    // The low three address bits are dropped: every register is addressed as a 64-bit word.
    always_comb begin
        region_hit = (i_req_addr & ~clint_mask) == clint_bar;
        word_idx   = i_req_addr[13:3];
        target     = tgt_none;
        if (region_hit) begin
            if (i_req_addr[15:3] == mtime_word)
                target = tgt_mtime;
            else if (i_req_addr[15:14] == 2'b00 && word_idx < msip_words)
                target = tgt_msip;
            else if (i_req_addr[15:14] == 2'b01 && word_idx < hart_count)
                target = tgt_mtimecmp;
        end
    end

    always_comb begin
        for (int b = 0; b < 8; b++)
            wr_mask[8*b +: 8] = {8{i_req_wstrb[b]}};
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_data = '0;
        case (target)
            tgt_mtime: rd_data = mtime;
            tgt_mtimecmp: begin
                for (int h = 0; h < cpu_max; h++)
                    if (word_idx == 11'(h)) rd_data = mtimecmp[h];
            end
            tgt_msip: begin
                for (int h = 0; h < cpu_max; h++) begin
                    if (word_idx == 11'(h / 2)) begin
                        if (h % 2 == 0) rd_data[0]  = msip[h];
                        else            rd_data[32] = msip[h];
                    end
                end
            end
            default: ;
        endcase
    end

    // A same-cycle mtime write overrides the increment; unwritten bytes keep the pre-increment value.
    always_comb begin
        mtime_next = tick ? mtime + 64'd1 : mtime;
        if (wr_en && target == tgt_mtime)
            mtime_next = (mtime & ~wr_mask) | (i_req_wdata & wr_mask);
    end

    // ---------------- architectural state ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime  <= '0;
            msip   <= '0;
            o_mtip <= '0;
        end else begin
            mtime <= mtime_next;
            for (int h = 0; h < cpu_max; h++) begin
                o_mtip[h] <= mtime >= mtimecmp[h];
                if (wr_en && target == tgt_msip && word_idx == 11'(h / 2)) begin
                    if (h % 2 == 0) begin
                        if (i_req_wstrb[0]) msip[h] <= i_req_wdata[0];
                    end else begin
                        if (i_req_wstrb[4]) msip[h] <= i_req_wdata[32];
                    end
                end
            end
        end
    end

    // NOTE: the compare file has an architectural reset value (all ones), so it is built from resettable flops, not RAM.
    always_ff @(posedge i_clk) begin
        for (int h = 0; h < cpu_max; h++) begin
            if (i_rst)
                mtimecmp[h] <= '1;
            else if (wr_en && target == tgt_mtimecmp && word_idx == 11'(h))
                mtimecmp[h] <= (mtimecmp[h] & ~wr_mask) | (i_req_wdata & wr_mask);
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
        end else if (accept) begin
            o_resp_err   <= target == tgt_none;
            o_resp_rdata <= (i_req_write || target == tgt_none) ? '0 : rd_data;
        end
    end

    assign o_msip  = msip;
    assign o_mtime = mtime;

endmodule

// File: tb/tb_clint_responder.sv
// Bench for clint_responder: transaction-level model checked every cycle, plus directed literal checks.
module tb_clint_responder;

    localparam int NH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [47:0]   req_addr;
    logic          req_write;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [63:0]   resp_rdata;
    logic          resp_err;
    logic [NH-1:0] msip;
    logic [NH-1:0] mtip;
    logic [63:0]   mtime;

    int n_tests = 0;
    int n_fail  = 0;

    clint_responder #(.cpu_max(NH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_msip       (msip),
        .o_mtip       (mtip),
        .o_mtime      (mtime)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_live = 1'b0;
    logic          m_busy;
    logic [63:0]   m_rdata;
    logic          m_err;
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [NH-1:0] m_mtip;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // 0 = fault, 1 = msip pair (idx = even hart), 2 = mtimecmp (idx = hart), 3 = mtime
    function automatic int decode(input logic [47:0] a, output int idx);
        logic [63:0] off;
        idx = 0;
        if (a < 48'h200_0000 || a >= 48'h201_0000) return 0;
        off = 64'(a) - 64'h200_0000;
        if (off / 8 == 64'hBFF8 / 8) return 3;
        if (off < 64'h4000) begin
            idx = int'(off / 8) * 2;
            return (idx < NH) ? 1 : 0;
        end
        if (off < 64'h8000) begin
            idx = int'((off - 64'h4000) / 8);
            return (idx < NH) ? 2 : 0;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        int          kind;
        int          idx;
        logic [63:0] next_time;
        if (rst) begin
            m_live  = 1'b1;
            m_busy  = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            m_mtime = '0;
            m_msip  = '0;
            m_mtip  = '0;
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        end else begin
            for (int h = 0; h < NH; h++) m_mtip[h] = m_mtime >= m_cmp[h];
            next_time = m_mtime + 64'd1;
            if (m_busy) begin
                if (resp_ready) m_busy = 1'b0;
            end else if (req_valid) begin
                m_busy  = 1'b1;
                kind    = decode(req_addr, idx);
                m_err   = (kind == 0);
                m_rdata = '0;
                case (kind)
                    1: begin
                        if (req_write) begin
                            if (req_wstrb[0]) m_msip[idx] = req_wdata[0];
                            if (idx + 1 < NH && req_wstrb[4]) m_msip[idx+1] = req_wdata[32];
                        end else begin
                            m_rdata[0] = m_msip[idx];
                            if (idx + 1 < NH) m_rdata[32] = m_msip[idx+1];
                        end
                    end
                    2: begin
                        if (req_write) m_cmp[idx] = merge(m_cmp[idx], req_wdata, req_wstrb);
                        else           m_rdata = m_cmp[idx];
                    end
                    3: begin
                        if (req_write) next_time = merge(m_mtime, req_wdata, req_wstrb);
                        else           m_rdata = m_mtime;
                    end
                    default: ;
                endcase
            end
            m_mtime = next_time;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_req_ready",  64'(req_ready),  64'(!m_busy));
            check("cyc_resp_valid", 64'(resp_valid), 64'(m_busy));
            if (m_busy) begin
                check("cyc_resp_rdata", resp_rdata,     m_rdata);
                check("cyc_resp_err",   64'(resp_err),  64'(m_err));
            end
            check("cyc_mtime", mtime,     m_mtime);
            check("cyc_msip",  64'(msip), 64'(m_msip));
            check("cyc_mtip",  64'(mtip), 64'(m_mtip));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [63:0] rd;
    logic        er;

    task automatic do_req(input logic [47:0] a, input logic w, input logic [63:0] d, input logic [7:0] s,
                          output logic [63:0] rdata_o, output logic err_o);
        int n;
        req_addr   = a;
        req_write  = w;
        req_wdata  = d;
        req_wstrb  = s;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("handshake_in_time", 64'(n < 20), 64'd1);
        rdata_o    = resp_rdata;
        err_o      = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_mtime",      mtime,            64'd0);
        check("rst_req_ready",  64'(req_ready),   64'd1);
        check("rst_resp_valid", 64'(resp_valid),  64'd0);
        check("rst_rdata",      resp_rdata,       64'd0);
        check("rst_err",        64'(resp_err),    64'd0);
        check("rst_msip",       64'(msip),        64'd0);
        check("rst_mtip",       64'(mtip),        64'd0);

        // mtime read three cycles after reset release
        repeat (3) @(posedge clk);
        #1;
        do_req(48'h200_BFF8, 1'b0, '0, 8'h00, rd, er);
        check("mtime_read_val", rd,      64'd3);
        check("mtime_read_err", 64'(er), 64'd0);

        // mtimecmp[1] = 0x40: timer interrupt one cycle after mtime reaches it
        do_req(48'h200_4008, 1'b1, 64'h40, 8'hFF, rd, er);
        check("cmp1_write_err", 64'(er), 64'd0);
        n = 0;
        while (mtime != 64'h40 && n < 200) begin @(posedge clk); #1; n++; end
        check("mtime_reaches_40", mtime, 64'h40);
        check("mtip_not_yet", 64'(mtip), 64'h0);
        @(posedge clk); #1;
        check("mtip1_rises", 64'(mtip), 64'h2);

        // msip pair write and readback, alignment and strobes
        do_req(48'h200_0000, 1'b1, 64'h0000_0001_0000_0001, 8'hFF, rd, er);
        check("msip_write_err", 64'(er),   64'd0);
        check("msip_harts01",   64'(msip), 64'h3);
        do_req(48'h200_0000, 1'b0, '0, 8'h00, rd, er);
        check("msip_read",      rd,        64'h0000_0001_0000_0001);
        do_req(48'h200_0004, 1'b0, '0, 8'h00, rd, er);
        check("msip_read_unaligned", rd,   64'h0000_0001_0000_0001);
        do_req(48'h200_0008, 1'b1, 64'h0000_0001_0000_0001, 8'h0F, rd, er);
        check("msip_strobe_lo", 64'(msip), 64'h7);
        do_req(48'h200_0008, 1'b0, '0, 8'h00, rd, er);
        check("msip_read_w1",   rd,        64'h1);

        // faults: no state change, zero data
        do_req(48'h1000_0000, 1'b0, '0, 8'h00, rd, er);
        check("io1_err",   64'(er), 64'd1);
        check("io1_rdata", rd,      64'd0);
        do_req(48'h200_1000, 1'b0, '0, 8'h00, rd, er);
        check("hole_err",   64'(er), 64'd1);
        check("hole_rdata", rd,      64'd0);
        do_req(48'h200_1000, 1'b1, '1, 8'hFF, rd, er);
        check("hole_write_err", 64'(er), 64'd1);
        do_req(48'h200_4020, 1'b1, 64'h0, 8'hFF, rd, er);
        check("cmp_hart4_err", 64'(er), 64'd1);
        do_req(48'h200_0010, 1'b0, '0, 8'h00, rd, er);
        check("msip_hart4_err", 64'(er), 64'd1);
        do_req(48'h200_BFF0, 1'b0, '0, 8'h00, rd, er);
        check("near_mtime_err", 64'(er), 64'd1);
        check("msip_after_faults", 64'(msip), 64'h7);

        // stalled response, with a competing request held on the port, then reset
        req_valid = 1'b1; req_addr = 48'h200_4008; req_write = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 48'h200_0000; req_write = 1'b1; req_wdata = '0; req_wstrb = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_ready", 64'(req_ready),  64'd0);
            check("stall_rdata", resp_rdata,      64'h40);
            @(posedge clk); #1;
        end
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("drop_resp_valid", 64'(resp_valid), 64'd0);
        check("drop_mtime",      mtime,           64'd0);
        check("drop_msip",       64'(msip),       64'd0);

        // mtime wrap clears the timer interrupt
        do_req(48'h200_4008, 1'b1, 64'h40, 8'hFF, rd, er);
        do_req(48'h200_BFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
        check("wrap_mtime", mtime,     64'd0);
        check("wrap_mtip",  64'(mtip), 64'hF);
        @(posedge clk); #1;
        check("wrap_mtip_clear", 64'(mtip), 64'h0);
        check("wrap_mtime_next", mtime,     64'd1);

        // partial mtime write: written bytes replace, others keep pre-increment value
        do_req(48'h200_BFFC, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, rd, er);
        check("mtime_strobe", mtime, 64'h0000_0000_5566_7789);

        // mtimecmp reset value and byte-strobed update
        do_req(48'h200_4018, 1'b0, '0, 8'h00, rd, er);
        check("cmp3_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(48'h200_4000, 1'b1, 64'hAA, 8'h01, rd, er);
        do_req(48'h200_4000, 1'b0, '0, 8'h00, rd, er);
        check("cmp0_strobe", rd, 64'hFFFF_FFFF_FFFF_FFAA);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clint_responder.md
CLINT_RESPONDER -- requirements
Module: clint_responder

Interface
REQ-001 SHALL have parameter cpu_max, default 4, number of harts served (1..8).
REQ-002 SHALL have port i_clk  in  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port i_req_valid  in  1  request present.
REQ-005 SHALL have port o_req_ready  out  1  request accepted when both this and valid are high.
REQ-006 SHALL have port i_req_addr  in  48  byte address (CFG_CPU_ADDR_BITS).
REQ-007 SHALL have port i_req_write  in  1  1=write, 0=read.
REQ-008 SHALL have port i_req_wdata  in  64  write data.
REQ-009 SHALL have port i_req_wstrb  in  8  byte enables.
REQ-010 SHALL have port o_resp_valid  out  1  response present.
REQ-011 SHALL have port i_resp_ready  in  1  response consumed.
REQ-012 SHALL have port o_resp_rdata  out  64  read data; 0 on writes and errors.
REQ-013 SHALL have port o_resp_err  out  1  access fault.
REQ-014 SHALL have port o_msip  out  cpu_max  software interrupt per hart.
REQ-015 SHALL have port o_mtip  out  cpu_max  timer interrupt per hart.
REQ-016 SHALL have port o_mtime  out  64  current mtime.

Function
REQ-017 SHALL decode the region as a hit when (i_req_addr AND NOT CLINT_MASK) equals CLINT_BAR (0x2000000, 64 KB window); offset = addr[15:0].
REQ-018 SHALL implement a two-state FSM: IDLE (o_req_ready=1, o_resp_valid=0) and RESP (o_req_ready=0, o_resp_valid=1).
REQ-019 SHALL move IDLE->RESP on the cycle a request is accepted; response is valid the next cycle (latency 1).
REQ-020 SHALL stay in RESP holding rdata/err stable until i_resp_ready=1, then return to IDLE; no back-to-back acceptance in the same cycle.
REQ-021 SHALL map msip[h] at offset 0x0000+4*h (bit 0 only; bits 31:1 read 0); the 64-bit word packs harts 2k (low half) and 2k+1 (high half).
REQ-022 SHALL map mtimecmp[h] at offset 0x4000+8*h, 64-bit, byte-strobed.
REQ-023 SHALL map mtime at offset 0xBFF8, 64-bit, byte-strobed.
REQ-024 SHALL respond with o_resp_err=1, no state change, for region miss, hart index >= cpu_max, or an unmapped offset; reads of unmapped offsets inside the region also fault.
REQ-025 SHALL treat the address as 8-byte aligned (addr[2:0] ignored); wstrb selects bytes.
REQ-026 SHALL increment mtime by 1 per increment event, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-027 SHALL give a mtime write priority over an increment in the same cycle (written bytes take the written value, unwritten bytes keep the pre-increment value).
REQ-028 SHALL register o_mtip[h] = (mtime >= mtimecmp[h]), unsigned, one cycle after either operand changes.
REQ-029 SHALL make write effects visible to reads issued in the next accepted request.

Reset
REQ-030 SHALL, on i_rst=1 at a clock edge, set FSM=IDLE, mtime=0, all mtimecmp=all ones, all msip=0, o_mtip=0, o_resp_rdata=0, o_resp_err=0.
REQ-031 SHALL drop an in-flight response when reset asserts in RESP; no response is presented after reset.

Configuration
REQ-032 SHALL honour macro CLINT_RTC_TICK_EN: when defined, add input port i_rtc_tick (1 bit) and increment mtime only on cycles where i_rtc_tick=1.
REQ-033 SHALL, when CLINT_RTC_TICK_EN is undefined, omit i_rtc_tick and increment mtime every clock cycle.

Verification
REQ-034 SHALL cover: reset, then read 0x2000000+0xBFF8 -> resp next cycle, err=0, rdata = cycle count since reset release (no macro).
REQ-035 SHALL cover: write 0x2004008 wdata=0x40 wstrb=0xFF (hart 1) -> o_mtip[1] rises exactly one cycle after mtime reaches 0x40; other harts stay 0.
REQ-036 SHALL cover: write 0x2000000 wdata=0x0000_0001_0000_0001 -> o_msip[0]=1, o_msip[1]=1; read back rdata=0x0000_0001_0000_0001.
REQ-037 SHALL cover: read 0x10000000 (IO1) and 0x2001000 -> o_resp_err=1, rdata=0, no register changed.
REQ-038 SHALL cover: hold i_resp_ready=0 for 5 cycles -> o_resp_valid, rdata stable, o_req_ready=0; assert i_rst during this -> o_resp_valid=0 next cycle.
REQ-039 SHALL cover: write mtime=0xFFFF_FFFF_FFFF_FFFF -> next increment yields 0 and o_mtip clears for mtimecmp=0x40.
